text_mode_renderer: RTL and testbench
=====================================

// Module: text_mode_renderer
// PURPOSE
//  Downstream of the video timing controller: takes pixel position plus syncs, fetches char/attribute
//  from external text RAM and glyph row from external font ROM, outputs 12-bit RGB.
//  8x16 cells, CGA 16-colour palette, blink attribute, hardware cursor.
//  Syncs delayed to stay aligned with RGB.
// PARAMETERS
//  H_PIXELS     800   visible width; COLS = H_PIXELS/8 (100)
//  V_PIXELS     600   visible height; ROWS = V_PIXELS/16 floor (37); lines >= ROWS*16 blank
//  CURSOR_START 14    first cell scanline of underline cursor (runs to 15)
// PORTS
//  pixel_clk   in   1     pixel clock, all logic rising-edge
//  reset_n     in   1     asynchronous active-low reset
//  en          in   1     pipeline advance; low = every register holds
//  h_pos       in   clog2(H_PIXELS)  current x from timing controller
//  v_pos       in   clog2(V_PIXELS)  current y from timing controller
//  h_sync_in   in   1     horizontal sync from timing controller
//  v_sync_in   in   1     vertical sync from timing controller
//  cursor_en   in   1     cursor display enable
//  cursor_col  in   7     cursor column (0..COLS-1)
//  cursor_row  in   6     cursor row (0..ROWS-1)
//  text_addr   out  clog2(COLS*ROWS)  text RAM address (registered)
//  text_data   in   16    {attr[7:0],char[7:0]}, valid 1 clk after addr sampled (sync RAM)
//  font_addr   out  12    {char[7:0],scanline[3:0]} (combinational from text_data)
//  font_data   in   8     glyph row, bit7 = leftmost pixel, valid 1 clk after addr (sync ROM)
//  rgb         out  12    {R[3:0],G[3:0],B[3:0]} (registered)
//  h_sync_out  out  1     h_sync_in delayed 4 clk
//  v_sync_out  out  1     v_sync_in delayed 4 clk
// BEHAVIOUR
//  Reset: text_addr=0, rgb=0, sync pipelines filled with the values sampled from *_sync_in after reset
//   (reset value 1), frame_cnt=0, all metadata regs 0.
//  Pipeline (edges counted from edge E1 that samples h_pos/v_pos, only edges with en=1 count):
//   E1: text_addr <= (v_pos>>4)*COLS + (h_pos>>3); latch x[2:0], y[3:0], active, cursor_hit, syncs.
//   E2: RAM samples text_addr; text_data valid after E2; font_addr = {text_data[7:0], y_d2}.
//   E3: ROM samples font_addr; attr <= text_data[15:8]; metadata advances.
//   E4: rgb <= colour of pixel; h_sync_out/v_sync_out <= sync of same pixel. Latency exactly 4.
//  active = h_pos<H_PIXELS && v_pos<ROWS*16; inactive -> rgb=0, text_addr holds last value.
//  Pixel: bit = font_data[7-x]; fg=attr[3:0], bg={1'b0,attr[6:4]}, blink=attr[7].
//   blink && frame_cnt[4] -> bit forced 0 (text hidden).
//   cursor_hit (cursor_en && cell==cursor pos && y>=CURSOR_START) && frame_cnt[3] -> bit forced 1.
//    Cursor wins over blink.
//   rgb = palette(bit ? fg : bg); palette = standard CGA (0=000,1=00A,...,6=A50,7=AAA,8=555,...,15=FFF).
//  frame_cnt: 5-bit, +1 on the en cycle with h_pos==0 && v_pos==0; wraps 31->0.
//  Out-of-range cursor_col/row: cursor never shown, no error.
//  reset_n assert mid-frame: all regs clear immediately; after release output valid from 4th en edge.
//  en low mid-line: no register changes; resumes seamlessly, latency in en-edges unchanged.
// TESTING
//  Reset: reset_n=0 any cycle -> rgb=0, h/v_sync_out=1, text_addr=0 asynchronously.
//  Address: h_pos=17,v_pos=35 -> text_addr=2*100+2=202 after E1; font_addr={char,4'd3} after E2.
//  Pixel: char 0x41 attr 0x1E, font_data=0x80, x=0 -> rgb=FF5 (yellow) at E4; x=1 -> rgb=00A.
//  Blink: attr 0x9F, frame_cnt 16..31 -> bg colour only; frame_cnt 0..15 -> glyph shown.
//  Cursor: cursor_en=1 at (5,3), y=15, frame_cnt[3]=1 -> all 8 pixels of cell fg; y=13 -> glyph.
//  Syncs: pulse on h_sync_in -> same width on h_sync_out 4 en-edges later; en low 3 clk -> delay 7 clk.

Source files
------------

// File: rtl/text_mode_renderer.sv
// Text-mode video renderer: pixel position -> text RAM -> font ROM -> CGA palette RGB.
// Four-stage pipeline (8x16 cells, blink, underline cursor) with syncs delayed to match.
module text_mode_renderer #(
    parameter int H_PIXELS     = 800,
    parameter int V_PIXELS     = 600,
    parameter int CURSOR_START = 14
) (
    input  logic                                         pixel_clk,
    input  logic                                         reset_n,
    input  logic                                         en,
    input  logic [$clog2(H_PIXELS)-1:0]                  h_pos,
    input  logic [$clog2(V_PIXELS)-1:0]                  v_pos,
    input  logic                                         h_sync_in,
    input  logic                                         v_sync_in,
    input  logic                                         cursor_en,
    input  logic [6:0]                                   cursor_col,
    input  logic [5:0]                                   cursor_row,
    output logic [$clog2((H_PIXELS/8)*(V_PIXELS/16))-1:0] text_addr,
    input  logic [15:0]                                  text_data,
    output logic [11:0]                                  font_addr,
    input  logic [7:0]                                   font_data,
    output logic [11:0]                                  rgb,
    output logic                                         h_sync_out,
    output logic                                         v_sync_out
);

    localparam int HW       = $clog2(H_PIXELS);
    localparam int VW       = $clog2(V_PIXELS);
    localparam int COLS     = H_PIXELS / 8;
    localparam int ROWS     = V_PIXELS / 16;
    localparam int AW       = $clog2(COLS * ROWS);
    localparam int V_ACTIVE = ROWS * 16;

    logic [HW-4:0] cell_col;
    logic [VW-5:0] cell_row;
    logic [AW-1:0] cell_addr;
    logic          active;
    logic          cursor_hit;

    logic [2:0] x1, x2, x3;
    logic [3:0] y1, y2;
    logic       act1, act2, act3;
    logic       cur1, cur2, cur3;
    logic       hs1, hs2, hs3;
    logic       vs1, vs2, vs3;
    logic [7:0] attr;
    logic [4:0] frame_cnt;

    logic       lit;
    logic [3:0] colour;

    assign cell_col = h_pos[HW-1:3];
    assign cell_row = v_pos[VW-1:4];

    // Partial bottom text row (lines >= ROWS*16) is treated as blank border.
    always_comb begin
        active     = (int'(h_pos) < H_PIXELS) && (int'(v_pos) < V_ACTIVE);
        cell_addr  = AW'(int'(cell_row) * COLS + int'(cell_col));
        cursor_hit = cursor_en
                     && (int'(cell_col) == int'(cursor_col))
                     && (int'(cell_row) == int'(cursor_row))
                     && (int'(v_pos[3:0]) >= CURSOR_START);
    end

    assign font_addr = {text_data[7:0], y2};

    // Cursor is applied after blink so an underline stays visible on hidden text.
    always_comb begin
        lit = font_data[3'd7 - x3];
        if (attr[7] && frame_cnt[4])
            lit = 1'b0;
        if (cur3 && frame_cnt[3])
            lit = 1'b1;
        colour = lit ? attr[3:0] : {1'b0, attr[6:4]};
    end

    function automatic logic [11:0] cga(input logic [3:0] c);
        case (c)
            4'h0:    return 12'h000;
            4'h1:    return 12'h00A;
            4'h2:    return 12'h0A0;
            4'h3:    return 12'h0AA;
            4'h4:    return 12'hA00;
            4'h5:    return 12'hA0A;
            4'h6:    return 12'hA50;
            4'h7:    return 12'hAAA;
            4'h8:    return 12'h555;
            4'h9:    return 12'h55F;
            4'hA:    return 12'h5F5;
            4'hB:    return 12'h5FF;
            4'hC:    return 12'hF55;
            4'hD:    return 12'hF5F;
            4'hE:    return 12'hFF5;
            default: return 12'hFFF;
        endcase
    endfunction

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            text_addr  <= '0;
            x1 <= '0;  y1 <= '0;  act1 <= 1'b0;  cur1 <= 1'b0;
            x2 <= '0;  y2 <= '0;  act2 <= 1'b0;  cur2 <= 1'b0;
            x3 <= '0;  act3 <= 1'b0;  cur3 <= 1'b0;
            hs1 <= 1'b1;  hs2 <= 1'b1;  hs3 <= 1'b1;
            vs1 <= 1'b1;  vs2 <= 1'b1;  vs3 <= 1'b1;
            attr       <= '0;
            frame_cnt  <= '0;
            rgb        <= '0;
            h_sync_out <= 1'b1;
            v_sync_out <= 1'b1;
        end else if (en) begin
            if (active)
                text_addr <= cell_addr;
            x1   <= h_pos[2:0];
            y1   <= v_pos[3:0];
            act1 <= active;
            cur1 <= cursor_hit;
            hs1  <= h_sync_in;
            vs1  <= v_sync_in;

            x2   <= x1;
            y2   <= y1;
            act2 <= act1;
            cur2 <= cur1;
            hs2  <= hs1;
            vs2  <= vs1;

            attr <= text_data[15:8];
            x3   <= x2;
            act3 <= act2;
            cur3 <= cur2;
            hs3  <= hs2;
            vs3  <= vs2;

            rgb        <= act3 ? cga(colour) : 12'h000;
            h_sync_out <= hs3;
            v_sync_out <= vs3;

            if (h_pos == '0 && v_pos == '0)
                frame_cnt <= frame_cnt + 5'd1;
        end
    end

endmodule

// File: tb/tb_text_mode_renderer.sv
// Scoreboard bench for text_mode_renderer with behavioural text RAM and font ROM.
// Expected pixels come from an independent reference model of the cell/palette rules.
module tb_text_mode_renderer;

    logic        pixel_clk  = 1'b0;
    logic        reset_n    = 1'b0;
    logic        en         = 1'b0;
    logic [9:0]  h_pos      = '0;
    logic [9:0]  v_pos      = '0;
    logic        h_sync_in  = 1'b1;
    logic        v_sync_in  = 1'b1;
    logic        cursor_en  = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;
    logic [11:0] text_addr;
    logic [15:0] text_data  = '0;
    logic [11:0] font_addr;
    logic [7:0]  font_data  = '0;
    logic [11:0] rgb;
    logic        h_sync_out;
    logic        v_sync_out;

    logic [15:0] text_mem [0:4095];
    logic [7:0]  font_mem [0:4095];

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t       sb[$];
    int         checks     = 0;
    int         failures   = 0;
    int         clk_count  = 0;
    logic [4:0] model_frame = '0;
    logic       watch      = 1'b0;
    logic       seen       = 1'b0;
    int         t_seen     = 0;

    text_mode_renderer dut (
        .pixel_clk  (pixel_clk),
        .reset_n    (reset_n),
        .en         (en),
        .h_pos      (h_pos),
        .v_pos      (v_pos),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .text_addr  (text_addr),
        .text_data  (text_data),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .rgb        (rgb),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) clk_count <= clk_count + 1;

    // Synchronous memories share the pipeline enable so a stall freezes them too.
    always @(posedge pixel_clk) begin
        if (en) begin
            text_data <= text_mem[text_addr];
            font_data <= font_mem[font_addr];
        end
    end

    always @(negedge pixel_clk) begin
        if (watch && !seen && !h_sync_out) begin
            seen   = 1'b1;
            t_seen = clk_count;
        end
    end

    function automatic logic [11:0] palette_ref(input logic [3:0] c);
        logic [11:0] table_rgb [0:15];
        table_rgb = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                      12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
        return table_rgb[c];
    endfunction

    function automatic logic [11:0] model_rgb(input logic [9:0] h, input logic [9:0] v);
        int          col, row, addr;
        logic [15:0] w;
        logic [7:0]  g;
        logic        b;
        if (int'(h) >= 800 || int'(v) >= 592)
            return 12'h000;
        col  = int'(h) / 8;
        row  = int'(v) / 16;
        addr = row * 100 + col;
        w    = text_mem[addr];
        g    = font_mem[{w[7:0], v[3:0]}];
        b    = g[3'd7 - h[2:0]];
        if (w[15] && model_frame[4])
            b = 1'b0;
        if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row)
            && int'(v[3:0]) >= 14 && model_frame[3])
            b = 1'b1;
        return palette_ref(b ? w[11:8] : {1'b0, w[14:12]});
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                                 input logic hs, input logic vs);
        exp_t e;
        h_pos     = h;
        v_pos     = v;
        h_sync_in = hs;
        v_sync_in = vs;
        en        = 1'b1;
        if (h == 10'd0 && v == 10'd0)
            model_frame = model_frame + 5'd1;
        e.rgb = model_rgb(h, v);
        e.hs  = hs;
        e.vs  = vs;
        sb.push_back(e);
        @(posedge pixel_clk);
        #1;
        if (sb.size() == 4) begin
            e = sb.pop_front();
            checkOutput("rgb", 32'(rgb), 32'(e.rgb));
            checkOutput("h_sync_out", 32'(h_sync_out), 32'(e.hs));
            checkOutput("v_sync_out", 32'(v_sync_out), 32'(e.vs));
        end
    endtask

    task automatic hold_cycles(input int n);
        en = 1'b0;
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask

    task automatic flush_inactive();
        repeat (3) applyStimulus(10'd800, 10'd600, 1'b1, 1'b1);
    endtask

    task automatic advance_frames(input int n);
        repeat (n) begin
            flush_inactive();
            applyStimulus(10'd0, 10'd0, 1'b1, 1'b1);
        end
        flush_inactive();
    endtask

    task automatic probe(input string tag, input logic [9:0] h, input logic [9:0] v,
                         input logic [11:0] want);
        applyStimulus(h, v, 1'b1, 1'b1);
        flush_inactive();
        checkOutput(tag, 32'(rgb), 32'(want));
    endtask

    task automatic measure_sync_delay(input string tag, input int holds, input int want);
        int t0;
        repeat (4) applyStimulus(10'd200, 10'd100, 1'b1, 1'b1);
        t0    = clk_count;
        seen  = 1'b0;
        watch = 1'b1;
        applyStimulus(10'd201, 10'd100, 1'b0, 1'b1);
        if (holds > 0)
            hold_cycles(holds);
        repeat (6) applyStimulus(10'd202, 10'd100, 1'b1, 1'b1);
        watch = 1'b0;
        checkOutput(tag, seen ? 32'(t_seen - t0) : 32'd999, 32'(want));
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            text_mem[a] = 16'($urandom);
            font_mem[a] = 8'($urandom);
        end
        text_mem[202]  = 16'h1E41;
        font_mem[{8'h41, 4'd3}] = 8'h80;
        text_mem[110]  = 16'h9F42;
        for (int y = 0; y < 16; y++)
            font_mem[{8'h42, 4'(y)}] = 8'hFF;
        text_mem[305]  = 16'h0743;
        font_mem[{8'h43, 4'd13}] = 8'h3C;
        font_mem[{8'h43, 4'd14}] = 8'h00;
        font_mem[{8'h43, 4'd15}] = 8'h00;
        text_mem[3699] = 16'h0744;
        font_mem[{8'h44, 4'd15}] = 8'h00;

        repeat (2) @(posedge pixel_clk);
        #1;
        checkOutput("reset_rgb", 32'(rgb), 32'h000);
        checkOutput("reset_hsync", 32'(h_sync_out), 32'd1);
        checkOutput("reset_vsync", 32'(v_sync_out), 32'd1);
        checkOutput("reset_text_addr", 32'(text_addr), 32'd0);
        @(negedge pixel_clk);
        reset_n = 1'b1;

        applyStimulus(10'd16, 10'd35, 1'b1, 1'b1);
        applyStimulus(10'd17, 10'd35, 1'b1, 1'b1);
        checkOutput("text_addr", 32'(text_addr), 32'd202);
        applyStimulus(10'd18, 10'd35, 1'b1, 1'b1);
        checkOutput("font_addr", 32'(font_addr), 32'h413);
        applyStimulus(10'd19, 10'd35, 1'b1, 1'b1);
        checkOutput("pixel_x0", 32'(rgb), 32'hFF5);
        applyStimulus(10'd20, 10'd35, 1'b1, 1'b1);
        checkOutput("pixel_x1", 32'(rgb), 32'h00A);

        for (int h = 0; h < 48; h++)
            applyStimulus(10'(h), 10'd35, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++)
            applyStimulus(10'($urandom_range(0, 850)), 10'($urandom_range(1, 620)),
                          1'($urandom), 1'($urandom));
        flush_inactive();

        probe("blink_visible", 10'd80, 10'd20, 12'hFFF);
        advance_frames(16);
        probe("blink_hidden", 10'd80, 10'd20, 12'h00A);
        probe("blink_hidden_edge", 10'd87, 10'd31, 12'h00A);

        cursor_en  = 1'b1;
        cursor_col = 7'd5;
        cursor_row = 6'd3;
        advance_frames(8);
        for (int h = 40; h < 48; h++)
            applyStimulus(10'(h), 10'd63, 1'b1, 1'b1);
        probe("cursor_y15_first", 10'd40, 10'd63, 12'hAAA);
        probe("cursor_y15_last", 10'd47, 10'd63, 12'hAAA);
        probe("cursor_y13_fg", 10'd42, 10'd61, 12'hAAA);
        probe("cursor_y13_bg", 10'd40, 10'd61, 12'h000);
        probe("blink_hidden_f24", 10'd80, 10'd20, 12'h00A);
        advance_frames(8);
        probe("cursor_phase_off", 10'd40, 10'd63, 12'h000);
        probe("blink_visible_wrap", 10'd80, 10'd20, 12'hFFF);

        advance_frames(8);
        cursor_col = 7'd110;
        probe("cursor_col_out_of_range", 10'd799, 10'd591, 12'h000);
        cursor_col = 7'd99;
        cursor_row = 6'd36;
        probe("cursor_last_cell", 10'd799, 10'd591, 12'hAAA);
        probe("blank_line", 10'd799, 10'd592, 12'h000);
        probe("blank_column", 10'd800, 10'd100, 12'h000);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(10'($urandom_range(0, 850)), 10'($urandom_range(1, 620)),
                          1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0)
                hold_cycles(int'($urandom_range(1, 3)));
        end
        flush_inactive();

        measure_sync_delay("sync_delay", 0, 4);
        measure_sync_delay("sync_delay_stalled", 3, 7);

        repeat (4) applyStimulus(10'd16, 10'd35, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_rgb", 32'(rgb), 32'h000);
        checkOutput("midreset_hsync", 32'(h_sync_out), 32'd1);
        checkOutput("midreset_vsync", 32'(v_sync_out), 32'd1);
        checkOutput("midreset_text_addr", 32'(text_addr), 32'd0);
        sb.delete();
        model_frame = '0;
        repeat (2) @(posedge pixel_clk);
        @(negedge pixel_clk);
        reset_n = 1'b1;
        cursor_en = 1'b0;
        probe("after_reset_pixel", 10'd16, 10'd35, 12'hFF5);
        probe("after_reset_blink", 10'd80, 10'd20, 12'hFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
